// File: rtl/mem_lsu_pkg.sv
// Shared CPU definitions for the memory stage: LSU FSM states, load/store opcodes
// and the alignment rule used to reject accesses before they reach the bus.
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_RESP = 2'd2
    } lsu_state_e;

    typedef enum logic [2:0] {
        LD_NONE = 3'b000,
        LD_LB   = 3'b001,
        LD_LH   = 3'b010,
        LD_LW   = 3'b011,
        LD_LBU  = 3'b100,
        LD_LHU  = 3'b101
    } load_op_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_SB   = 2'b01,
        ST_SH   = 2'b10,
        ST_SW   = 2'b11
    } store_op_e;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] ld, input logic [1:0] st,
                                           input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (st)
            ST_SH:   bad = addr_lo[0];
            ST_SW:   bad = (addr_lo != 2'b00);
            default: ;
        endcase
        case (ld)
            LD_LH, LD_LHU: bad = bad | addr_lo[0];
            LD_LW:         bad = bad | (addr_lo != 2'b00);
            default:       ;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Byte-lane strobe and data replication for stores onto the 32-bit bus.
module lsu_store_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  store_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        wstrb = 4'b0000;
        wdata = data;
        case (store_op)
            ST_SB: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{data[7:0]}};
            end
            ST_SH: begin
                wstrb = 4'b0011 << addr_lo;
                wdata = {2{data[15:0]}};
            end
            ST_SW:   wstrb = 4'b1111;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: latches the EX op, runs one bus access at a time
// and stalls the pipeline until the final handshake (or a response timeout).
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        flush,
    input  logic        wb_en_EX,
    input  logic        fwb_en_EX,
    input  logic [2:0]  is_load_EX,
    input  logic [1:0]  is_store_EX,
    input  logic [5:0]  rd_addr_EX,
    input  logic [31:0] alu_out_EX,
    input  logic [31:0] rs2_data_EX,
    output logic        req_valid,
    output logic        req_write,
    output logic [31:0] req_addr,
    output logic [3:0]  req_wstrb,
    output logic [31:0] req_wdata,
    input  logic        req_ready,
    input  logic        resp_valid,
    output logic        wb_en_MEM,
    output logic        fwb_en_MEM,
    output logic [2:0]  is_load_MEM,
    output logic [5:0]  rd_addr_MEM,
    output logic [31:0] alu_out_MEM,
    output logic        DM_CEB,
    output logic [1:0]  DM_shift,
    output logic        mem_stall,
    output logic        misalign_err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    lsu_state_e     state;
    logic [CW-1:0]  wait_cnt;
    logic [1:0]     is_store_MEM;
    logic [31:0]    rs2_data_MEM;

    logic advance;
    logic ex_is_load;
    logic ex_access;
    logic ex_misaligned;

    assign advance       = !mem_stall && !stall_in;
    assign ex_is_load    = is_load_EX inside {LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU};
    assign ex_access     = ex_is_load || (is_store_EX != ST_NONE);
    assign ex_misaligned = is_misaligned(is_load_EX, is_store_EX, alu_out_EX[1:0]);

    // The pipeline is held for the whole access, including its last handshake cycle.
    assign mem_stall = (state != S_IDLE);
    assign req_valid = (state == S_REQ);
    assign req_write = req_valid && (is_store_MEM != ST_NONE);
    assign req_addr  = {alu_out_MEM[31:2], 2'b00};
    assign DM_CEB    = !((state == S_WAIT_RESP) && resp_valid);
    assign DM_shift  = alu_out_MEM[1:0];

    lsu_store_align u_store_align (
        .store_op (is_store_MEM),
        .addr_lo  (alu_out_MEM[1:0]),
        .data     (rs2_data_MEM),
        .wstrb    (req_wstrb),
        .wdata    (req_wdata)
    );

    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            wb_en_MEM    <= 1'b0;
            fwb_en_MEM   <= 1'b0;
            is_load_MEM  <= LD_NONE;
            is_store_MEM <= ST_NONE;
            rd_addr_MEM  <= '0;
            alu_out_MEM  <= '0;
            rs2_data_MEM <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (advance) begin
                        rd_addr_MEM  <= rd_addr_EX;
                        alu_out_MEM  <= alu_out_EX;
                        rs2_data_MEM <= rs2_data_EX;
                        if (flush) begin
                            wb_en_MEM    <= 1'b0;
                            fwb_en_MEM   <= 1'b0;
                            is_load_MEM  <= LD_NONE;
                            is_store_MEM <= ST_NONE;
                        end else begin
                            is_load_MEM  <= is_load_EX;
                            is_store_MEM <= is_store_EX;
                            if (ex_misaligned) begin
                                wb_en_MEM    <= 1'b0;
                                fwb_en_MEM   <= 1'b0;
                                misalign_err <= 1'b1;
                            end else begin
                                wb_en_MEM  <= wb_en_EX;
                                fwb_en_MEM <= fwb_en_EX;
                                if (ex_access) state <= S_REQ;
                            end
                        end
                    end
                end
                S_REQ: begin
                    if (req_ready) begin
                        wait_cnt <= '0;
                        // Stores are posted; only loads wait for data.
                        state    <= (is_store_MEM != ST_NONE) ? S_IDLE : S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    if (resp_valid) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        state        <= S_IDLE;
                        misalign_err <= 1'b1;
                        wb_en_MEM    <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: expected bus requests are queued when an op is
// driven and compared every cycle the DUT presents them.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall_in, flush, wb_en_EX, fwb_en_EX;
    logic [2:0]  is_load_EX;
    logic [1:0]  is_store_EX;
    logic [5:0]  rd_addr_EX;
    logic [31:0] alu_out_EX, rs2_data_EX;
    logic        req_valid, req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        req_ready, resp_valid;
    logic        wb_en_MEM, fwb_en_MEM;
    logic [2:0]  is_load_MEM;
    logic [5:0]  rd_addr_MEM;
    logic [31:0] alu_out_MEM;
    logic        DM_CEB;
    logic [1:0]  DM_shift;
    logic        mem_stall, misalign_err;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } exp_req_t;

    exp_req_t exp_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int ceb_lows = 0;
    int req_seen = 0;
    int ceb_mark;
    int req_mark;
    int n_wait;
    logic [1:0] last_shift = 2'b00;

    mem_lsu #(.TIMEOUT_CYC(255)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_in     (stall_in),
        .flush        (flush),
        .wb_en_EX     (wb_en_EX),
        .fwb_en_EX    (fwb_en_EX),
        .is_load_EX   (is_load_EX),
        .is_store_EX  (is_store_EX),
        .rd_addr_EX   (rd_addr_EX),
        .alu_out_EX   (alu_out_EX),
        .rs2_data_EX  (rs2_data_EX),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wstrb    (req_wstrb),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .wb_en_MEM    (wb_en_MEM),
        .fwb_en_MEM   (fwb_en_MEM),
        .is_load_MEM  (is_load_MEM),
        .rd_addr_MEM  (rd_addr_MEM),
        .alu_out_MEM  (alu_out_MEM),
        .DM_CEB       (DM_CEB),
        .DM_shift     (DM_shift),
        .mem_stall    (mem_stall),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock cycle of bus stimulus; compares any presented request against the queue head.
    task automatic bus_cycle(input logic rdy, input logic rv);
        exp_req_t e;
        req_ready  = rdy;
        resp_valid = rv;
        #1;
        if (!DM_CEB) begin
            ceb_lows++;
            last_shift = DM_shift;
        end
        if (req_valid) begin
            req_seen++;
            if (exp_q.size() == 0) begin
                check("req_unexpected", 32'(req_valid), 32'd0);
            end else begin
                e = exp_q[0];
                check("req_write", 32'(req_write), 32'(e.write));
                check("req_addr", req_addr, e.addr);
                check("req_wstrb", 32'(req_wstrb), 32'(e.strb));
                if (e.write) check("req_wdata", req_wdata, e.wdata);
                if (rdy) void'(exp_q.pop_front());
            end
        end
        @(negedge clk);
    endtask

    // Presents one EX op for a single cycle; returns at the negedge after its capture edge.
    task automatic ex_op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr,
                         input logic [31:0] data, input logic wb, input logic rdy);
        is_load_EX  = ld;
        is_store_EX = st;
        alu_out_EX  = addr;
        rs2_data_EX = data;
        rd_addr_EX  = 6'd5;
        wb_en_EX    = wb;
        fwb_en_EX   = wb;
        bus_cycle(rdy, 1'b0);
        is_load_EX  = LD_NONE;
        is_store_EX = ST_NONE;
        wb_en_EX    = 1'b0;
        fwb_en_EX   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        stall_in = 1'b0; flush = 1'b0; wb_en_EX = 1'b0; fwb_en_EX = 1'b0;
        is_load_EX = LD_NONE; is_store_EX = ST_NONE; rd_addr_EX = '0;
        alu_out_EX = '0; rs2_data_EX = '0; req_ready = 1'b0; resp_valid = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_mem_stall", 32'(mem_stall), 32'd0);
        check("rst_dm_ceb", 32'(DM_CEB), 32'd1);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_wb_en", 32'(wb_en_MEM), 32'd0);
        check("rst_is_load", 32'(is_load_MEM), 32'd0);
        check("rst_alu_out", alu_out_MEM, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // SW, ready immediately: one stall cycle, no read strobe.
        ceb_mark = ceb_lows;
        exp_q.push_back('{write: 1'b1, addr: 32'h100, strb: 4'b1111, wdata: 32'hDEADBEEF});
        ex_op(LD_NONE, ST_SW, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1);
        check("sw_req_valid", 32'(req_valid), 32'd1);
        check("sw_stall", 32'(mem_stall), 32'd1);
        bus_cycle(1'b1, 1'b0);
        check("sw_stall_done", 32'(mem_stall), 32'd0);
        check("sw_req_done", 32'(req_valid), 32'd0);
        check("sw_no_ceb", 32'(ceb_lows - ceb_mark), 32'd0);

        // SB to the top byte lane.
        exp_q.push_back('{write: 1'b1, addr: 32'h200, strb: 4'b1000, wdata: 32'hA5A5A5A5});
        ex_op(LD_NONE, ST_SB, 32'h203, 32'h000000A5, 1'b0, 1'b1);
        bus_cycle(1'b1, 1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // SH to the upper halfword.
        exp_q.push_back('{write: 1'b1, addr: 32'h004, strb: 4'b1100, wdata: 32'h12341234});
        ex_op(LD_NONE, ST_SH, 32'h006, 32'hCAFE1234, 1'b0, 1'b1);
        bus_cycle(1'b1, 1'b0);
        check("sh_drained", 32'(exp_q.size()), 32'd0);

        // LH with late ready and late response: request held stable, single read strobe.
        ceb_mark = ceb_lows;
        exp_q.push_back('{write: 1'b0, addr: 32'h300, strb: 4'b0000, wdata: 32'h0});
        ex_op(LD_LH, ST_NONE, 32'h302, 32'h0, 1'b1, 1'b0);
        check("lh_req_valid", 32'(req_valid), 32'd1);
        repeat (3) bus_cycle(1'b0, 1'b0);
        bus_cycle(1'b1, 1'b0);
        check("lh_wait_stall", 32'(mem_stall), 32'd1);
        check("lh_drained", 32'(exp_q.size()), 32'd0);
        bus_cycle(1'b0, 1'b0);
        bus_cycle(1'b0, 1'b1);
        check("lh_ceb_pulses", 32'(ceb_lows - ceb_mark), 32'd1);
        check("lh_dm_shift", 32'(last_shift), 32'd2);
        check("lh_is_load", 32'(is_load_MEM), 32'(LD_LH));
        check("lh_wb_en", 32'(wb_en_MEM), 32'd1);
        check("lh_rd_addr", 32'(rd_addr_MEM), 32'd5);
        check("lh_stall_done", 32'(mem_stall), 32'd0);

        // Misaligned SW and LW: error pulse, no request, writeback suppressed.
        ex_op(LD_NONE, ST_SW, 32'h101, 32'h0, 1'b1, 1'b1);
        check("sw_mis_err", 32'(misalign_err), 32'd1);
        check("sw_mis_wb", 32'(wb_en_MEM), 32'd0);
        check("sw_mis_req", 32'(req_valid), 32'd0);
        check("sw_mis_stall", 32'(mem_stall), 32'd0);
        bus_cycle(1'b1, 1'b0);
        check("sw_mis_pulse_end", 32'(misalign_err), 32'd0);
        ex_op(LD_LW, ST_NONE, 32'h102, 32'h0, 1'b1, 1'b1);
        check("lw_mis_err", 32'(misalign_err), 32'd1);
        check("lw_mis_fwb", 32'(fwb_en_MEM), 32'd0);

        // Flush captures a bubble.
        flush = 1'b1;
        ex_op(LD_LW, ST_NONE, 32'h400, 32'h0, 1'b1, 1'b1);
        flush = 1'b0;
        check("flush_is_load", 32'(is_load_MEM), 32'd0);
        check("flush_wb_en", 32'(wb_en_MEM), 32'd0);
        check("flush_req", 32'(req_valid), 32'd0);

        // Downstream hold blocks capture.
        stall_in = 1'b1;
        ex_op(LD_LW, ST_NONE, 32'h500, 32'h0, 1'b1, 1'b0);
        check("hold_is_load", 32'(is_load_MEM), 32'd0);
        check("hold_req", 32'(req_valid), 32'd0);
        stall_in = 1'b0;

        // LW with response withheld: timeout after 255 wait cycles.
        ceb_mark = ceb_lows;
        exp_q.push_back('{write: 1'b0, addr: 32'h600, strb: 4'b0000, wdata: 32'h0});
        ex_op(LD_LW, ST_NONE, 32'h600, 32'h0, 1'b1, 1'b1);
        bus_cycle(1'b1, 1'b0);
        n_wait = 0;
        while (mem_stall && n_wait < 400) begin
            bus_cycle(1'b0, 1'b0);
            n_wait++;
        end
        check("to_wait_cycles", 32'(n_wait), 32'd255);
        check("to_err", 32'(misalign_err), 32'd1);
        check("to_wb_en", 32'(wb_en_MEM), 32'd0);
        check("to_no_ceb", 32'(ceb_lows - ceb_mark), 32'd0);

        // Reset during WAIT_RESP abandons the load.
        exp_q.push_back('{write: 1'b0, addr: 32'h700, strb: 4'b0000, wdata: 32'h0});
        ex_op(LD_LW, ST_NONE, 32'h700, 32'h0, 1'b1, 1'b1);
        bus_cycle(1'b1, 1'b0);
        repeat (2) bus_cycle(1'b0, 1'b0);
        check("mid_stall", 32'(mem_stall), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_stall", 32'(mem_stall), 32'd0);
        check("mid_rst_req", 32'(req_valid), 32'd0);
        check("mid_rst_ceb", 32'(DM_CEB), 32'd1);
        check("mid_rst_wb", 32'(wb_en_MEM), 32'd0);
        check("mid_rst_alu", alu_out_MEM, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        req_mark = req_seen;
        ceb_mark = ceb_lows;
        repeat (6) bus_cycle(1'b1, 1'b1);
        check("post_rst_no_req", 32'(req_seen - req_mark), 32'd0);
        check("post_rst_no_ceb", 32'(ceb_lows - ceb_mark), 32'd0);
        check("post_rst_stall", 32'(mem_stall), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        resp_valid = 1'b0;
        req_ready  = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
